// File: rtl/common_pkg.sv
// Shared CLIC types: priority/index widths and the packed entries vector.
// The threshold occupies the top slot (ThreshIdx) of Entries.
package common_pkg;

    localparam int unsigned PrioWidth  = 3;
    localparam int unsigned NrEntries  = 4;
    localparam int unsigned IndexWidth = $clog2(NrEntries);
    localparam int unsigned ThreshIdx  = NrEntries - 1;

    typedef logic [PrioWidth-1:0]  Prio;
    typedef logic [IndexWidth-1:0] Index;
    typedef Prio [NrEntries-1:0]   Entries;

endpackage

// File: rtl/can_clic_tstack.sv
// LIFO of saved thresholds. push+pop in the same cycle is a net replace:
// neither sp nor the stored entries change.
module can_clic_tstack
    import common_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic [PrioWidth-1:0] din,
    output logic [SP_W-1:0] sp,
    output logic            full_c,
    output logic [PrioWidth-1:0] top_c
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    Prio mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_c  = (sp == SP_W'(DEPTH));
    assign do_push = push && !pop && !full_c;
    assign do_pop  = pop && !push && (sp != '0);
    assign top_c   = (sp == '0) ? '0 : mem[AddrW'(sp - SP_W'(1))];

    // Stack pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (do_push) begin
            sp <= sp + SP_W'(1);
        end else if (do_pop) begin
            sp <= sp - SP_W'(1);
        end
    end

    // Saved-threshold storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[AddrW'(sp)] <= din;
        end
    end

endmodule

// File: rtl/can_clic_nest.sv
// Core-side CLIC nesting controller: offers the arbiter winner to the core
// over req/ack, clears the taken source's pending flag, raises the threshold
// and restores preempted levels on mret.
// Optional: define CAN_CLIC_NEST_ERR_EN for a sticky err on mret at depth 0
// or irq_ack without irq_req; otherwise err is tied to 0.
module can_clic_nest
    import common_pkg::*;
#(
    parameter int unsigned         DEPTH           = 4,
    parameter logic [PrioWidth-1:0] RESET_THRESHOLD = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NrEntries*PrioWidth-1:0] entries,
    input  logic                           is_interrupt,
    input  logic [IndexWidth-1:0]          index,
    output logic [PrioWidth-1:0]           threshold,
    output logic                           irq_req,
    output logic [IndexWidth-1:0]          irq_id,
    output logic [PrioWidth-1:0]           irq_prio,
    input  logic                           irq_ack,
    input  logic                           mret,
    output logic                           clr_valid,
    output logic [IndexWidth-1:0]          clr_index,
    output logic [$clog2(DEPTH+1)-1:0]     depth,
    output logic                           err
);

    localparam int unsigned SpW = $clog2(DEPTH + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [0:0] state_q, state_d;
    Entries     ent;
    logic       ack_ok, mret_ok;
    logic       full_c;
    Prio        top_c;
    logic [SpW-1:0] sp;

    Prio        thr_d, prio_d;
    Index       id_d, clr_idx_d;
    logic       req_d, clr_v_d;

    assign ent     = Entries'(entries);
    assign ack_ok  = (state_q == REQ) && irq_ack;
    assign mret_ok = mret && (sp != '0);
    assign depth   = sp;

    can_clic_tstack #(.DEPTH(DEPTH), .SP_W(SpW)) u_tstack (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (ack_ok),
        .pop    (mret_ok),
        .din    (threshold),
        .sp     (sp),
        .full_c (full_c),
        .top_c  (top_c)
    );

    // Next-state and next-output logic for the offer handshake
    always_comb begin
        state_d   = state_q;
        thr_d     = threshold;
        req_d     = irq_req;
        id_d      = irq_id;
        prio_d    = irq_prio;
        clr_v_d   = 1'b0;
        clr_idx_d = clr_index;
        case (state_q)
            IDLE: begin
                if (is_interrupt && !full_c && !mret) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    id_d    = index;
                    prio_d  = ent[index];
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_d   = IDLE;
                    req_d     = 1'b0;
                    clr_v_d   = 1'b1;
                    clr_idx_d = irq_id;
                    thr_d     = irq_prio;
                end
            end
            default: state_d = IDLE;
        endcase
        if (mret_ok && !ack_ok) begin
            thr_d = top_c;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            threshold <= RESET_THRESHOLD;
            irq_req   <= 1'b0;
            irq_id    <= '0;
            irq_prio  <= '0;
            clr_valid <= 1'b0;
            clr_index <= '0;
        end else begin
            state_q   <= state_d;
            threshold <= thr_d;
            irq_req   <= req_d;
            irq_id    <= id_d;
            irq_prio  <= prio_d;
            clr_valid <= clr_v_d;
            clr_index <= clr_idx_d;
        end
    end

`ifdef CAN_CLIC_NEST_ERR_EN
    logic err_d;

    assign err_d = err || (mret && (sp == '0)) || (irq_ack && (state_q != REQ));

    // Sticky protocol error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_can_clic_nest.sv
// Bench for can_clic_nest: directed nesting scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_can_clic_nest;
    import common_pkg::*;

    localparam int unsigned DEPTH   = 2;
    localparam int unsigned SpW     = $clog2(DEPTH + 1);
    localparam Prio         RST_THR = 3'd0;

    logic                           clk = 1'b0;
    logic                           rst_n = 1'b0;
    logic [NrEntries*PrioWidth-1:0] entries;
    logic                           is_interrupt = 1'b0;
    logic [IndexWidth-1:0]          index = '0;
    logic [PrioWidth-1:0]           threshold;
    logic                           irq_req;
    logic [IndexWidth-1:0]          irq_id;
    logic [PrioWidth-1:0]           irq_prio;
    logic                           irq_ack = 1'b0;
    logic                           mret = 1'b0;
    logic                           clr_valid;
    logic [IndexWidth-1:0]          clr_index;
    logic [SpW-1:0]                 depth;
    logic                           err;

    Entries ent = '0;
    assign entries = ent;

    always #5 clk = ~clk;

    can_clic_nest #(.DEPTH(DEPTH), .RESET_THRESHOLD(RST_THR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entries      (entries),
        .is_interrupt (is_interrupt),
        .index        (index),
        .threshold    (threshold),
        .irq_req      (irq_req),
        .irq_id       (irq_id),
        .irq_prio     (irq_prio),
        .irq_ack      (irq_ack),
        .mret         (mret),
        .clr_valid    (clr_valid),
        .clr_index    (clr_index),
        .depth        (depth),
        .err          (err)
    );

    // Reference model state
    int m_thr;
    int m_stack[$];
    bit m_req;
    int m_id, m_prio;
    bit m_clr;
    int m_clr_idx;
    bit m_err;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Arbiter stand-in: highest source priority strictly above threshold wins
    task automatic arb(output bit hit, output int win);
        int best;
        best = -1;
        for (int i = 0; i < int'(NrEntries) - 1; i++) begin
            if (int'(ent[i]) > m_thr && (best < 0 || int'(ent[i]) > int'(ent[best])))
                best = i;
        end
        hit = (best >= 0);
        win = hit ? best : 0;
    endtask

    task automatic model_update(input bit rst, input bit hit, input int win,
                                input bit ack, input bit mr);
        bit was_req;
        int sp;
        if (!rst) begin
            m_thr = int'(RST_THR);
            m_stack.delete();
            m_req = 0; m_id = 0; m_prio = 0; m_clr = 0; m_clr_idx = 0; m_err = 0;
            return;
        end
        was_req = m_req;
        sp      = m_stack.size();
        m_clr   = 0;
        if (mr && sp == 0) m_err = 1;
        if (ack && !was_req) m_err = 1;
        if (was_req && ack) begin
            if (!(mr && sp > 0)) m_stack.push_back(m_thr);
            m_thr     = m_prio;
            m_clr     = 1;
            m_clr_idx = m_id;
            m_req     = 0;
        end else begin
            if (mr && sp > 0) m_thr = m_stack.pop_back();
            if (!was_req && hit && sp < int'(DEPTH) && !mr) begin
                m_req  = 1;
                m_id   = win;
                m_prio = int'(ent[win]);
            end
        end
    endtask

    task automatic check_all();
        int exp_err;
`ifdef CAN_CLIC_NEST_ERR_EN
        exp_err = int'(m_err);
`else
        exp_err = 0;
`endif
        chk("threshold", int'(threshold), m_thr);
        chk("irq_req",   int'(irq_req),   int'(m_req));
        chk("irq_id",    int'(irq_id),    m_id);
        chk("irq_prio",  int'(irq_prio),  m_prio);
        chk("clr_valid", int'(clr_valid), int'(m_clr));
        if (m_clr) chk("clr_index", int'(clr_index), m_clr_idx);
        chk("depth",     int'(depth),     m_stack.size());
        chk("err",       int'(err),       exp_err);
    endtask

    task automatic step(input bit rst, input bit ack, input bit mr);
        bit hit;
        int win;
        @(negedge clk);
        arb(hit, win);
        rst_n        = rst;
        irq_ack      = ack;
        mret         = mr;
        is_interrupt = hit;
        index        = Index'(win);
        @(posedge clk);
        model_update(rst, hit, win, ack, mr);
        #1;
        check_all();
    endtask

    initial begin
        int exp_err_dir;
        bit r_rst, r_ack, r_mr;
`ifdef CAN_CLIC_NEST_ERR_EN
        exp_err_dir = 1;
`else
        exp_err_dir = 0;
`endif
        m_thr = int'(RST_THR);

        // Reset and idle
        ent = '0;
        step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 0); step(1, 0, 0);
        chk("rst_thr", int'(threshold), 0);
        chk("rst_req", int'(irq_req), 0);
        chk("rst_depth", int'(depth), 0);

        // First offer: s2 wins with prio 3, held while un-acked
        ent[0] = 3'd1; ent[1] = 3'd2; ent[2] = 3'd3;
        step(1, 0, 0);
        chk("offer_req", int'(irq_req), 1);
        chk("offer_id", int'(irq_id), 2);
        chk("offer_prio", int'(irq_prio), 3);
        ent[1] = 3'd7;
        repeat (5) step(1, 0, 0);
        chk("hold_id", int'(irq_id), 2);
        chk("hold_prio", int'(irq_prio), 3);
        ent[1] = 3'd2;
        step(1, 1, 0);
        chk("ack1_thr", int'(threshold), 3);
        chk("ack1_depth", int'(depth), 1);
        chk("ack1_clr", int'(clr_valid), 1);
        chk("ack1_clr_idx", int'(clr_index), 2);
        ent[2] = 3'd0;
        step(1, 0, 0);
        chk("post_ack_idle", int'(irq_req), 0);
        chk("clr_one_cycle", int'(clr_valid), 0);

        // Nesting: s0 prio 5 preempts threshold 3, stack becomes full
        ent[0] = 3'd5;
        step(1, 0, 0);
        chk("nest_id", int'(irq_id), 0);
        chk("nest_prio", int'(irq_prio), 5);
        step(1, 1, 0);
        chk("nest_thr", int'(threshold), 5);
        chk("nest_depth", int'(depth), 2);
        ent[0] = 3'd0;

        // Full: s1 prio 7 must wait for an mret
        ent[1] = 3'd7;
        repeat (3) step(1, 0, 0);
        chk("full_no_req", int'(irq_req), 0);
        step(1, 0, 1);
        chk("mret1_thr", int'(threshold), 3);
        chk("mret1_depth", int'(depth), 1);
        step(1, 0, 0);
        chk("after_full_req", int'(irq_req), 1);
        chk("after_full_id", int'(irq_id), 1);

        // ack + mret together: net replace
        step(1, 1, 1);
        chk("repl_thr", int'(threshold), 7);
        chk("repl_depth", int'(depth), 1);
        chk("repl_clr_idx", int'(clr_index), 1);
        ent[1] = 3'd0;
        step(1, 0, 1);
        chk("mret2_thr", int'(threshold), 0);
        chk("mret2_depth", int'(depth), 0);

        // mret with empty stack
        step(1, 0, 1);
        chk("underflow_thr", int'(threshold), 0);
        chk("underflow_err", int'(err), exp_err_dir);

        // Reset while an offer is outstanding
        ent[0] = 3'd4;
        step(1, 0, 0);
        chk("pre_rst_req", int'(irq_req), 1);
        step(0, 0, 0);
        chk("rst_drop_req", int'(irq_req), 0);
        chk("rst_drop_clr", int'(clr_valid), 0);
        chk("rst_drop_thr", int'(threshold), int'(RST_THR));
        ent = '0;
        step(1, 0, 0);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (m_clr) ent[m_clr_idx] = 3'd0;
            if ($urandom_range(0, 5) == 0)
                ent[$urandom_range(0, int'(NrEntries) - 2)] = Prio'($urandom);
            r_ack = m_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            r_mr  = ($urandom_range(0, 9) == 0);
            r_rst = ($urandom_range(0, 499) != 0);
            step(r_rst, r_ack, r_mr);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
